// File: rtl/snn_axil_regfile.sv
// snn_axil_regfile
// AXI4-Lite slave register file in front of the SNN coprocessor.
//   - Image memory: IMAGE_SIZE 8-bit pixels, PPW pixels per bus word, one
//     byte strobe per pixel lane. Readable and writable while idle.
//   - CTRL   (word IMG_WORDS):   bit0 START (write-1, reads 0), bit1 IRQ_EN.
//   - STATUS (word IMG_WORDS+1): bit0 BUSY, bit1 DONE (W1C), [15:8] DIGIT.
//   - Illegal accesses return SLVERR.
// Ports:
//   ACLK, ARESETN                 clock, synchronous active-low reset
//   AW*/W*/B*                     AXI4-Lite write channels (AW and W decoupled)
//   AR*/R*                        AXI4-Lite read channels
//   INFER_DONE, INFERED_DIGIT     completion pulse and result from the SNN
//   IMAGE                         pixel array to the SNN
//   NEW_IMAGE                     one-cycle start pulse to the SNN
//   IRQ                           level interrupt, DONE & IRQ_EN
module snn_axil_regfile #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int IMAGE_SIZE     = 256,
    parameter int PIXEL_BITS     = 8
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]                  AWPROT,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        WVALID,
    output logic                        WREADY,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RVALID,
    input  logic                        RREADY,
    input  logic                        INFER_DONE,
    input  logic [7:0]                  INFERED_DIGIT,
    output logic [PIXEL_BITS-1:0]       IMAGE [IMAGE_SIZE],
    output logic                        NEW_IMAGE,
    output logic                        IRQ
);

    localparam int PPW       = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB  = $clog2(PPW);
    localparam int IMG_WORDS = IMAGE_SIZE / PPW;
    localparam int WI_W      = AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int IDX_W     = (IMG_WORDS > 1) ? $clog2(IMG_WORDS) : 1;

    localparam logic [WI_W-1:0] WI_CTRL = WI_W'(IMG_WORDS);
    localparam logic [WI_W-1:0] WI_STAT = WI_W'(IMG_WORDS + 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write hold registers
    logic                      aw_held, w_held;
    logic [WI_W-1:0]           aw_wi;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [PPW-1:0]            w_strb;

    logic                      bvalid, rvalid;
    logic [1:0]                bresp, rresp;
    logic [AXI_DATA_WIDTH-1:0] rdata;

    logic       busy, done, irq_en, new_image;
    logic [7:0] digit;

    // Address/protection bits below word granularity carry no information.
    logic unused;
    assign unused = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    // ---------------- write decode (on the held request) ----------------
    logic             commit, wr_img, wr_ctrl, wr_stat;
    logic             start_req, start_ok, img_we, irq_we, done_clr, wr_err;
    logic [IDX_W-1:0] wr_idx;

    assign commit    = aw_held & w_held & ~bvalid;
    assign wr_img    = aw_wi < WI_CTRL;
    assign wr_ctrl   = aw_wi == WI_CTRL;
    assign wr_stat   = aw_wi == WI_STAT;
    assign wr_idx    = aw_wi[IDX_W-1:0];
    assign start_req = wr_ctrl & w_strb[0] & w_data[0];
    assign start_ok  = commit & start_req & ~busy;
    assign img_we    = commit & wr_img & ~busy;
    assign irq_we    = commit & wr_ctrl & w_strb[0];
    assign done_clr  = commit & wr_stat & w_strb[0] & w_data[1];
    assign wr_err    = (wr_img & busy) | (start_req & busy) | ~(wr_img | wr_ctrl | wr_stat);

    // ---------------- read decode ----------------
    logic [WI_W-1:0]           ar_wi;
    logic [IDX_W-1:0]          ar_idx;
    logic [PPW-1:0][7:0]       lane_rd;
    logic [AXI_DATA_WIDTH-1:0] rd_data;
    logic [1:0]                rd_resp;

    assign ar_wi  = ARADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_idx = ar_wi[IDX_W-1:0];

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (ar_wi < WI_CTRL) begin
            rd_data = lane_rd;
        end else if (ar_wi == WI_CTRL) begin
            rd_data[1] = irq_en;
        end else if (ar_wi == WI_STAT) begin
            rd_data[0]    = busy;
            rd_data[1]    = done;
            rd_data[15:8] = digit;
        end else begin
            rd_resp = RESP_SLVERR;
        end
    end

    // ---------------- image storage, one bank per byte lane ----------------
    for (genvar k = 0; k < PPW; k++) begin : g_lane
        logic [IMG_WORDS-1:0][7:0] mem;

        always_ff @(posedge ACLK) begin
            if (!ARESETN)
                mem <= '0;
            else if (img_we && w_strb[k])
                mem[wr_idx] <= w_data[8*k +: 8];
        end

        assign lane_rd[k] = mem[ar_idx];

        for (genvar w = 0; w < IMG_WORDS; w++) begin : g_px
            assign IMAGE[w*PPW + k] = mem[w];
        end
    end

    // ---------------- channel and control state ----------------
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_held   <= 1'b0;
            aw_wi     <= '0;
            w_held    <= 1'b0;
            w_data    <= '0;
            w_strb    <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            irq_en    <= 1'b0;
            digit     <= '0;
            new_image <= 1'b0;
        end else begin
            // Handshake needs an empty holder, commit needs a full one,
            // so the two branches never compete.
            if (AWVALID && AWREADY) begin
                aw_held <= 1'b1;
                aw_wi   <= AWADDR[AXI_ADDR_WIDTH-1:ADDR_LSB];
            end else if (commit) begin
                aw_held <= 1'b0;
            end

            if (WVALID && WREADY) begin
                w_held <= 1'b1;
                w_data <= WDATA;
                w_strb <= WSTRB;
            end else if (commit) begin
                w_held <= 1'b0;
            end

            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && BREADY) begin
                bvalid <= 1'b0;
            end

            new_image <= start_ok;

            if (irq_we)
                irq_en <= w_data[1];

            if (start_ok)
                busy <= 1'b1;
            else if (INFER_DONE)
                busy <= 1'b0;

            // Completion beats a same-edge clear so no result is lost.
            if (INFER_DONE)
                done <= 1'b1;
            else if (start_ok || done_clr)
                done <= 1'b0;

            if (INFER_DONE)
                digit <= INFERED_DIGIT;

            if (ARVALID && ARREADY) begin
                rvalid <= 1'b1;
                rdata  <= rd_data;
                rresp  <= rd_resp;
            end else if (rvalid && RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Readies are gated by reset so they are low while it is asserted.
    assign AWREADY   = ARESETN & ~aw_held;
    assign WREADY    = ARESETN & ~w_held;
    assign ARREADY   = ARESETN & ~rvalid;
    assign BVALID    = bvalid;
    assign BRESP     = bresp;
    assign RVALID    = rvalid;
    assign RRESP     = rresp;
    assign RDATA     = rdata;
    assign NEW_IMAGE = new_image;
    assign IRQ       = done & irq_en;

endmodule

// File: doc/snn_axil_regfile.md
# snn_axil_regfile

Parametrised AXI4-Lite slave register file fronting the SNN coprocessor. It is the successor of the single-lane image loader and adds these features:
- configurable bus width, with several pixels packed per data word and per-lane byte strobes
- decoupled AW/W capture
- a START/BUSY/DONE control protocol and an interrupt output
- image read-back
- SLVERR responses for illegal accesses

It sits between the PS interconnect and the SNN core.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32: data bus width, 32 or 64. PPW = AXI_DATA_WIDTH/8 pixels per word.
- AXI_ADDR_WIDTH, 12: byte address width. ADDR_LSB = log2(PPW); word index WI = addr[AXI_ADDR_WIDTH-1:ADDR_LSB].
- IMAGE_SIZE, 256: number of pixels, a multiple of PPW. IMG_WORDS = IMAGE_SIZE/PPW.
- PIXEL_BITS, 8: fixed at 8, so one strobe bit maps to one pixel.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low; clock ACLK
- AWADDR  in  AXI_ADDR_WIDTH  write address
- AWPROT  in  3  ignored
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- WDATA  in  AXI_DATA_WIDTH  write data
- WSTRB  in  AXI_DATA_WIDTH/8  byte strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BRESP  out  2  OKAY=00 or SLVERR=10
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- ARADDR  in  AXI_ADDR_WIDTH  read address
- ARPROT  in  3  ignored
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- RDATA  out  AXI_DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- INFER_DONE  in  1  one-cycle pulse from the SNN when inference completes
- INFERED_DIGIT  in  8  result digit, valid with INFER_DONE
- IMAGE  out  PIXEL_BITS x IMAGE_SIZE  unpacked pixel array to the SNN
- NEW_IMAGE  out  1  one-cycle start pulse to the SNN
- IRQ  out  1  level interrupt

## Operation
Register map, by word index WI:
- 0..IMG_WORDS-1: image. Lane k of word w is pixel w*PPW+k. R/W, with per-lane strobes.
- IMG_WORDS+0, CTRL:
  - bit0 START: write 1 to start; always reads 0.
  - bit1 IRQ_EN: R/W.
  - Strobe lane 0 gates both bits.
- IMG_WORDS+1, STATUS:
  - bit0 BUSY, read-only.
  - bit1 DONE, sticky; write 1 to clear.
  - [15:8] DIGIT, read-only.
  - Other bits read 0.
- Any other WI: read returns 0 with SLVERR; write has no effect and returns SLVERR.

Write rules:
- A write to an image word while BUSY is discarded and returns SLVERR.
- START=1 while BUSY is ignored and returns SLVERR. IRQ_EN in the same write still applies.
- START=1 while idle pulses NEW_IMAGE for one cycle, sets BUSY and clears DONE.

Inference completion:
- On INFER_DONE: BUSY clears, DONE sets, DIGIT captures INFERED_DIGIT.
- INFER_DONE while idle still updates DIGIT and DONE.
- INFER_DONE on the same edge as a DONE write-1-to-clear: set wins.

IRQ = DONE & IRQ_EN.

Reset:
- All registers and the image array clear.
- All outputs are 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, NEW_IMAGE, IRQ, BRESP, RRESP, RDATA.
- In the first cycle after release, AWREADY, WREADY and ARREADY are 1.

## Timing
Write path:
- AW and W each have a one-entry hold register. AWREADY = !aw_held; WREADY = !w_held. The two may handshake in any order or in the same cycle.
- Commit edge: the first edge where aw_held & w_held & !BVALID.
  - Register updates and BVALID/BRESP take effect on that edge.
  - Both hold registers clear on that edge, so AWREADY/WREADY return high the next cycle.
- Minimum latency: handshake at edge E, BVALID high after edge E+1.
- BVALID holds until BREADY is sampled. While BVALID is held, a new AW/W may be captured but does not commit.
- NEW_IMAGE is high for exactly the one cycle following the START commit edge.

Read path:
- ARREADY = !RVALID.
- On AR handshake edge E, RDATA/RRESP are registered and RVALID=1 after E. Data reflects register state before E.
- RVALID/RDATA hold until RREADY. The edge where RVALID & RREADY clears RVALID.
- Throughput: 1 read per 2 cycles.

Concurrency:
- Read and write channels are independent. A same-edge read of a word being committed returns the old value.

Reset mid-transaction:
- Held AW/W are dropped and any pending B/R is cleared.
- A NEW_IMAGE pulse in flight is cut.

## Test plan
- 32-bit, all lanes: write word 0 = 0x04030201, WSTRB=0xF, then read word 0 -> BRESP=00, BVALID one cycle after the handshake; IMAGE[0..3]=1,2,3,4; RDATA=0x04030201, RRESP=00.
- Partial strobe: write word 1 = 0xAABBCCDD, WSTRB=0x5 over a prior value of 0 -> IMAGE[4]=0xDD, IMAGE[6]=0xBB, IMAGE[5]=IMAGE[7]=0.
- Decoupled channels: AW at cycle 3, W at cycle 7, BREADY held low for 5 cycles -> exactly one BVALID, rising after W; a second AW is accepted but does not commit until B completes.
- Start sequence:
  - CTRL=0x3 -> NEW_IMAGE high for 1 cycle; STATUS reads 0x1.
  - An image write now -> SLVERR and IMAGE unchanged.
  - INFER_DONE with digit 7 -> STATUS=0x0702, IRQ=1.
  - Write STATUS=0x2 -> IRQ=0.
- Errors: read WI=IMG_WORDS+5 -> RDATA=0, RRESP=10. START while BUSY -> BRESP=10, no NEW_IMAGE.
- Reset mid-write: AW held and W pending, then ARESETN low for 1 cycle -> BVALID never asserts; all outputs 0; image all 0.
